// File: rtl/mio_arb_pkg.sv
// Shared definitions for the MIO bus arbiter: FSM state codes, master
// indices and wait-counter sizing.
package mio_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_e;

  // Master indices as used by the picker and the owner register.
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Read latency is carried by a 4-bit counter, so 15 is the ceiling.
  localparam int RD_LAT_MAX = 15;
  localparam int CNT_W      = 4;

  // One-hot grant vector for a master index.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker. A lone requester wins outright;
// on a tie the requester that did not own the bus last time wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       win_valid,
  output logic       win_idx
);

  // Pick the winner from the request pair and the previous owner.
  always_comb begin
    win_valid = |req;
    win_idx   = 1'b0;
    case (req)
      2'b01:   win_idx = 1'b0;
      2'b10:   win_idx = 1'b1;
      2'b11:   win_idx = ~last_owner;
      default: win_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/mio_bus_arbiter.sv
// Two-master arbiter/sequencer in front of the MIO address decoder.
// One transaction at a time: IDLE (arbitrate + latch) -> ACCESS (one bus
// cycle, only place bus_mem_w can be high) -> WAIT (RD_LAT cycles) ->
// DONE (rdata valid, one-cycle ack) -> IDLE.
module mio_bus_arbiter
  import mio_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_mem_w,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [1:0]        grant,
  output logic              busy
);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] ACCESS = ST_ACCESS;
  localparam logic [1:0] WAIT   = ST_WAIT;
  localparam logic [1:0] DONE   = ST_DONE;

  // Latency clamped to what the 4-bit counter can hold.
  localparam logic [CNT_W-1:0] LAT =
    CNT_W'((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             owner;
  logic             last_owner;
  logic             pick_valid;
  logic             pick_idx;
  logic             go_done;

  rr_pick2 u_pick (
    .req        ({m1_req, m0_req}),
    .last_owner (last_owner),
    .win_valid  (pick_valid),
    .win_idx    (pick_idx)
  );

  // The cycle whose edge moves the FSM into DONE is also the cycle in which
  // bus_rdata is sampled, so ack and rdata appear together in DONE.
  assign go_done = ((state == ACCESS) && (LAT == '0)) ||
                   ((state == WAIT) && (cnt <= CNT_W'(1)));

  assign busy = (state != IDLE);

  // Sequencer FSM, wait counter and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      owner      <= M0;
      last_owner <= M1;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner <= pick_idx;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          cnt   <= LAT;
          state <= (LAT == '0) ? DONE : WAIT;
        end
        WAIT: begin
          // Saturating decrement; WAIT is left when the count reaches 0.
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
          if (go_done) state <= DONE;
        end
        DONE: begin
          last_owner <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus-side latch: address/data are captured on a win and then held, so
  // the RAM sees a stable address between transactions; the write strobe
  // is high only during the ACCESS cycle that follows the win.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_mem_w <= 1'b0;
      grant     <= 2'b00;
    end else begin
      bus_mem_w <= 1'b0;
      if ((state == IDLE) && pick_valid) begin
        bus_addr  <= pick_idx ? m1_addr  : m0_addr;
        bus_wdata <= pick_idx ? m1_wdata : m0_wdata;
        bus_mem_w <= pick_idx ? m1_we    : m0_we;
        grant     <= onehot2(pick_idx);
      end else if (state == DONE) begin
        grant <= 2'b00;
      end
    end
  end

  // Master-side response: one-cycle ack to the owner and its rdata capture.
  // Writes capture too; the master ignores rdata on a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      m0_ack <= go_done && (owner == M0);
      m1_ack <= go_done && (owner == M1);
      if (go_done && (owner == M0)) m0_rdata <= bus_rdata;
      if (go_done && (owner == M1)) m1_rdata <= bus_rdata;
    end
  end

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Bench for mio_bus_arbiter: three instances (RD_LAT 1, 0, 15) share all
// inputs. A transaction-schedule model checks every instance every cycle;
// a vector table and directed sequences cover the listed corner cases.
module tb_mio_bus_arbiter;

  localparam int NI = 3;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 15);
  endfunction

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, bus_rdata;

  logic [NI-1:0]       o_ack0, o_ack1, o_memw, o_busy;
  logic [NI-1:0][31:0] o_rd0, o_rd1, o_addr, o_wdata;
  logic [NI-1:0][1:0]  o_grant;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mio_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(lat_of(g))) u_dut (
      .clk       (clk),
      .rst       (rst),
      .m0_req    (m0_req),
      .m0_we     (m0_we),
      .m0_addr   (m0_addr),
      .m0_wdata  (m0_wdata),
      .m0_ack    (o_ack0[g]),
      .m0_rdata  (o_rd0[g]),
      .m1_req    (m1_req),
      .m1_we     (m1_we),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
      .m1_ack    (o_ack1[g]),
      .m1_rdata  (o_rd1[g]),
      .bus_addr  (o_addr[g]),
      .bus_wdata (o_wdata[g]),
      .bus_mem_w (o_memw[g]),
      .bus_rdata (bus_rdata),
      .grant     (o_grant[g]),
      .busy      (o_busy[g])
    );
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-schedule reference model ----------------
  // A transaction won at edge s occupies the bus after edges s..s+1+L:
  // write strobe after edge s, ack/rdata after edge s+1+L, free after s+2+L.
  int          en = 0;
  int          ms    [NI];
  bit          mact  [NI];
  bit          mwin  [NI];
  bit          mwe   [NI];
  bit          mlast [NI];
  logic [31:0] maddr [NI];
  logic [31:0] mwd   [NI];
  logic [31:0] mrd0  [NI];
  logic [31:0] mrd1  [NI];
  bit          kn0   [NI];
  bit          kn1   [NI];

  initial forever begin
    @(posedge clk);
    en++;
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        mact[k] = 0; mlast[k] = 1; maddr[k] = '0; mwd[k] = '0; mwe[k] = 0;
        mrd0[k] = '0; mrd1[k] = '0; kn0[k] = 1; kn1[k] = 1;
      end else if (mact[k]) begin
        if (en == ms[k] + 1 + lat_of(k)) begin
          if (mwin[k]) begin mrd1[k] = bus_rdata; kn1[k] = !mwe[k]; end
          else         begin mrd0[k] = bus_rdata; kn0[k] = !mwe[k]; end
        end
        if (en == ms[k] + 2 + lat_of(k)) begin
          mlast[k] = mwin[k];
          mact[k]  = 0;
        end
      end else if (m0_req || m1_req) begin
        mwin[k]  = (m0_req && m1_req) ? !mlast[k] : m1_req;
        ms[k]    = en;
        mact[k]  = 1;
        maddr[k] = mwin[k] ? m1_addr  : m0_addr;
        mwd[k]   = mwin[k] ? m1_wdata : m0_wdata;
        mwe[k]   = mwin[k] ? m1_we    : m0_we;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      logic [1:0] eg;
      logic       em, ea0, ea1;
      eg  = mact[k] ? (mwin[k] ? 2'b10 : 2'b01) : 2'b00;
      em  = mact[k] && mwe[k] && (en == ms[k]);
      ea0 = mact[k] && (en == ms[k] + 1 + lat_of(k)) && !mwin[k];
      ea1 = mact[k] && (en == ms[k] + 1 + lat_of(k)) &&  mwin[k];
      chk($sformatf("mdl%0d busy", k),  o_busy[k],  mact[k]);
      chk($sformatf("mdl%0d grant", k), o_grant[k], eg);
      chk($sformatf("mdl%0d mem_w", k), o_memw[k],  em);
      chk($sformatf("mdl%0d ack0", k),  o_ack0[k],  ea0);
      chk($sformatf("mdl%0d ack1", k),  o_ack1[k],  ea1);
      chk($sformatf("mdl%0d addr", k),  o_addr[k],  maddr[k]);
      chk($sformatf("mdl%0d wdata", k), o_wdata[k], mwd[k]);
      if (kn0[k]) chk($sformatf("mdl%0d rdata0", k), o_rd0[k], mrd0[k]);
      if (kn1[k]) chk($sformatf("mdl%0d rdata1", k), o_rd1[k], mrd1[k]);
    end
  end

  // ---------------- vector table (RD_LAT=1 instance) ----------------
  typedef struct {
    logic        rst, r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, brd;
    logic        e_ack0, e_ack1, e_memw;
    logic [1:0]  e_grant;
    logic        e_busy;
    logic [31:0] e_addr, e_wdata, e_rd1;
  } vec_t;

  vec_t vt [10];

  task automatic do_reset();
    rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    logic [31:0] A, D, B, W1, X, Z;
    int  who [4];
    int  at  [4];
    int  n, got;
    int  ackc [NI];

    A = 32'h0000_0010; D = 32'hDEAD_BEEF; B = 32'hFFFF_0200;
    W1 = 32'h1234_5678; X = 32'h0000_0055; Z = 32'h0;

    //          rst   r0    w0    a0            d0    r1    w1    a1 brd           ack0  ack1  memw  grant  busy  addr wdata rd1
    vt[0] = '{1'b1, 1'b1, 1'b1, A,            D,    1'b1, 1'b0, B, X,            1'b0, 1'b0, 1'b0, 2'b00, 1'b0, Z, Z,  Z};
    vt[1] = '{1'b1, 1'b1, 1'b1, A,            D,    1'b1, 1'b0, B, X,            1'b0, 1'b0, 1'b0, 2'b00, 1'b0, Z, Z,  Z};
    vt[2] = '{1'b0, 1'b1, 1'b1, A,            D,    1'b1, 1'b0, B, X,            1'b0, 1'b0, 1'b1, 2'b01, 1'b1, A, D,  Z};
    vt[3] = '{1'b0, 1'b1, 1'b0, 32'h20,       Z,    1'b1, 1'b0, B, X,            1'b0, 1'b0, 1'b0, 2'b01, 1'b1, A, D,  Z};
    vt[4] = '{1'b0, 1'b1, 1'b0, 32'h20,       Z,    1'b1, 1'b0, B, X,            1'b1, 1'b0, 1'b0, 2'b01, 1'b1, A, D,  Z};
    vt[5] = '{1'b0, 1'b0, 1'b0, 32'h20,       Z,    1'b1, 1'b0, B, X,            1'b0, 1'b0, 1'b0, 2'b00, 1'b0, A, D,  Z};
    vt[6] = '{1'b0, 1'b0, 1'b0, 32'h20,       Z,    1'b1, 1'b0, B, X,            1'b0, 1'b0, 1'b0, 2'b10, 1'b1, B, W1, Z};
    vt[7] = '{1'b0, 1'b0, 1'b0, 32'h20,       Z,    1'b1, 1'b0, B, X,            1'b0, 1'b0, 1'b0, 2'b10, 1'b1, B, W1, Z};
    vt[8] = '{1'b0, 1'b0, 1'b0, 32'h20,       Z,    1'b1, 1'b0, B, 32'h0000_000A, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, B, W1, 32'h0000_000A};
    vt[9] = '{1'b0, 1'b0, 1'b0, 32'h20,       Z,    1'b0, 1'b0, B, X,            1'b0, 1'b0, 1'b0, 2'b00, 1'b0, B, W1, 32'h0000_000A};

    rst = 1'b1; m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = W1; bus_rdata = X;

    for (int i = 0; i < 10; i++) begin
      rst = vt[i].rst; m0_req = vt[i].r0; m0_we = vt[i].w0;
      m0_addr = vt[i].a0; m0_wdata = vt[i].d0;
      m1_req = vt[i].r1; m1_we = vt[i].w1; m1_addr = vt[i].a1;
      bus_rdata = vt[i].brd;
      step();
      chk($sformatf("vec%0d ack0", i),  o_ack0[0],  vt[i].e_ack0);
      chk($sformatf("vec%0d ack1", i),  o_ack1[0],  vt[i].e_ack1);
      chk($sformatf("vec%0d mem_w", i), o_memw[0],  vt[i].e_memw);
      chk($sformatf("vec%0d grant", i), o_grant[0], vt[i].e_grant);
      chk($sformatf("vec%0d busy", i),  o_busy[0],  vt[i].e_busy);
      chk($sformatf("vec%0d addr", i),  o_addr[0],  vt[i].e_addr);
      chk($sformatf("vec%0d wdata", i), o_wdata[0], vt[i].e_wdata);
      chk($sformatf("vec%0d rdata1", i), o_rd1[0],  vt[i].e_rd1);
    end

    // Contention: both held, expect m0,m1,m0,m1 at cycles 3,7,11,15.
    do_reset();
    m0_we = 0; m1_we = 0; m0_req = 1; m1_req = 1; bus_rdata = X;
    n = 0;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      step();
      if (o_ack0[0] && n < 4) begin who[n] = 0; at[n] = c; n++; end
      if (o_ack1[0] && n < 4) begin who[n] = 1; at[n] = c; n++; end
    end
    chk("cont ack count", n, 4);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("cont owner%0d", i), who[i], i % 2);
      chk($sformatf("cont cycle%0d", i), at[i], 3 + 4 * i);
    end
    m0_req = 0; m1_req = 0;

    // Reset inside WAIT of an m0 read after a completed m0 transaction.
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0100;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (o_ack0[0]) begin got = 1; break; end
    end
    chk("rstseq first ack", got, 1);
    m0_req = 0; step();
    m0_req = 1; step();
    step();
    chk("rstseq in wait busy", o_busy[0], 1);
    rst = 1; step();
    chk("rstseq ack0 after rst", o_ack0[0], 0);
    chk("rstseq busy after rst", o_busy[0], 0);
    chk("rstseq grant after rst", o_grant[0], 2'b00);
    rst = 0; m1_req = 1; step();
    chk("rstseq tie to m0", o_grant[0], 2'b01);
    chk("rstseq no stale ack", o_ack0[0], 0);
    m0_req = 0; m1_req = 0;

    // Latency at RD_LAT 1 / 0 / 15 from a single m0 read.
    do_reset();
    for (int k = 0; k < NI; k++) ackc[k] = -1;
    m0_req = 1; m0_we = 0; m0_addr = 32'hA5A5_0004;
    for (int c = 1; c <= 30; c++) begin
      step();
      for (int k = 0; k < NI; k++) if (ackc[k] < 0 && o_ack0[k]) ackc[k] = c;
      if (o_busy[2] && ackc[2] < 0) chk("lat15 addr hold", o_addr[2], 32'hA5A5_0004);
    end
    chk("lat1 ack cycle",  ackc[0], 3);
    chk("lat0 ack cycle",  ackc[1], 2);
    chk("lat15 ack cycle", ackc[2], 17);
    m0_req = 0;

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      m0_req    = ($urandom_range(0, 2) != 0);
      m1_req    = ($urandom_range(0, 2) != 0);
      m0_we     = $urandom_range(0, 1) != 0;
      m1_we     = $urandom_range(0, 1) != 0;
      m0_addr   = $urandom;
      m1_addr   = $urandom;
      m0_wdata  = $urandom;
      m1_wdata  = $urandom;
      bus_rdata = $urandom;
      step();
    end
    rst = 0; m0_req = 0; m1_req = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mio_bus_arbiter.md
Name: mio_bus_arbiter

Overview:
- Two-master arbiter and sequencer in front of the MIO address decoder.
- Shares the single MIO bus (data RAM, VRAM, counter, switch/button/PS2 I/O) between master 0 (CPU) and master 1 (DMA/debug engine).
- Runs one registered transaction at a time:
  - drives the decoder's address, write-data and mem_w;
  - waits a fixed read latency;
  - returns read data with a one-cycle ack to the winning master.

Parameters:
- ADDR_W, 32, address width of masters and bus.
- DATA_W, 32, data width.
- RD_LAT, 1, cycles between the access cycle and sampling of bus_rdata; legal range 0..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  master 0 request; held high until m0_ack.
- m0_we  in  1  master 0 write (1) / read (0).
- m0_addr  in  ADDR_W  master 0 byte address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_ack  out  1  one-cycle completion pulse to master 0.
- m0_rdata  out  DATA_W  master 0 read data, valid while m0_ack is high.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  same as master 0, for master 1.
- bus_addr  out  ADDR_W  address to the MIO decoder.
- bus_wdata  out  DATA_W  write data to the MIO decoder.
- bus_mem_w  out  1  write strobe to the MIO decoder.
- bus_rdata  in  DATA_W  read data from the MIO decoder.
- grant  out  2  one-hot current owner; 00 when idle.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - state IDLE; grant 00; busy 0; bus_mem_w 0.
  - bus_addr and bus_wdata 0.
  - m0_ack and m1_ack 0; m0_rdata and m1_rdata 0.
  - last_owner = 1, so master 0 wins the first tie.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, that master wins.
  - If both are high, the master that is not last_owner wins (round robin).
  - On a win, latch the winner's addr, wdata and we. Set grant. Go to ACCESS.
- ACCESS (exactly 1 cycle):
  - bus_addr and bus_wdata come from the latch.
  - bus_mem_w = latched we. This is the only cycle bus_mem_w can be high.
  - Load the wait counter with RD_LAT.
  - Go to WAIT if RD_LAT > 0, else DONE.
- WAIT:
  - Decrement the counter; bus_mem_w 0; bus_addr held.
  - Go to DONE in the cycle the counter reaches 0. WAIT therefore lasts exactly RD_LAT cycles.
- DONE (1 cycle):
  - Sample bus_rdata into the winner's rdata register. Writes sample too; the value is don't-care.
  - Pulse the winner's ack for 1 cycle; the other ack stays 0.
  - last_owner <= winner; grant <= 00.
  - Go to IDLE.
- Latency: req high in IDLE at cycle t → ACCESS at t+1 → ack at t+2+RD_LAT (t+3 at default).
- Back-to-back:
  - A master still asserting req in the cycle after its ack is treated as a new request.
  - Issue rate is one transaction per 3+RD_LAT cycles.
  - A fair alternation under contention is guaranteed.
- bus_addr outside ACCESS/WAIT: holds the last latched value. This keeps the RAM read address stable and adds no glitches.
- rdata registers: hold their value until that master's next DONE.
- req dropped mid-transaction: the transaction completes and the ack still pulses. The master must ignore it. Requests are not cancelled.
- Inputs changing mid-transaction: m*_addr, m*_wdata and m*_we changes after the IDLE latch cycle have no effect.
- Reset mid-transaction: next cycle is IDLE, no ack issued, bus_mem_w 0, last_owner = 1.
- Width rule: no arithmetic on addresses or data. The counter is 4 bits, saturates at 0 and never wraps.

Decomposition:
- Package mio_arb_pkg holds:
  - state enum IDLE/ACCESS/WAIT/DONE (2-bit encoding);
  - constants M0 = 0, M1 = 1;
  - RD_LAT range limit 15;
  - counter width 4.
- One natural sub-module: rr_pick2, a combinational 2-way round-robin picker.
  - Inputs: req[1:0], last_owner.
  - Outputs: win_valid, win_idx.
  - Reused by future multi-requester arbiters.
- The FSM, latch and counter stay in the top.

Test Plan:
- Reset check: assert rst for 2 cycles with both reqs high → grant 00, busy 0, bus_mem_w 0, both acks 0. First grant is to master 0, at the first cycle after release.
- Master 0 write, RD_LAT=1: m0_req with addr 0x00000010, wdata 0xDEADBEEF, we=1 at t → at t+1 bus_addr 0x00000010, bus_wdata 0xDEADBEEF, bus_mem_w 1 for exactly that cycle; m0_ack at t+3 only.
- Master 1 read: m1 addr 0xFFFF0200 with bus_rdata driven 0x0000000A → m1_rdata 0x0000000A with m1_ack at t+3; m0_ack stays 0; bus_mem_w never high.
- Contention: both reqs held continuously for 4 transactions → acks in order m0, m1, m0, m1, each 4 cycles apart; grant one-hot and matching throughout.
- Reset mid-operation: assert rst in the WAIT cycle of an m0 read → no m0_ack ever; IDLE next cycle; a subsequent tie goes to m0.
- RD_LAT=0: m0 read at t → ack at t+2; and RD_LAT=15 → ack at t+17, bus_addr stable across all wait cycles.
